// File: rtl/srt4_div_ctrl.sv
// rtl/srt4_div_ctrl.sv - radix-4 SRT divider control FSM
// Sequences load, digit-recurrence iterations and final correction, with divide-by-zero and abort.
module srt4_div_ctrl #(
  parameter int ITERATIONS = 24,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             divisor_zero,
  input  logic             rem_neg,
  input  logic             done_ack,
  output logic             load_op,
  output logic             iter_en,
  output logic             iter_last,
  output logic             fix_en,
  output logic             busy,
  output logic             done,
  output logic             dz_err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             dz_q;
  logic             dz_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      iter_cnt <= '0;
      dz_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= cnt_nxt;
      dz_q     <= dz_nxt;
    end
  end

  // abort outranks every other transition, including the ITER->FIX exit
  always_comb begin
    state_nxt = state;
    cnt_nxt   = iter_cnt;
    dz_nxt    = dz_q;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          dz_nxt    = divisor_zero;
          state_nxt = divisor_zero ? DONE : INIT;
        end
      end
      INIT: begin
        cnt_nxt   = '0;
        state_nxt = abort ? IDLE : ITER;
      end
      ITER: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (iter_cnt == LAST_CNT) begin
          state_nxt = FIX;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = iter_cnt + CNT_W'(1);
        end
      end
      FIX: begin
        cnt_nxt   = '0;
        state_nxt = abort ? IDLE : DONE;
      end
      DONE: begin
        if (done_ack || abort) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // dz_err is held internally until the next accepted start but only shown alongside done
  always_comb begin
    load_op   = 1'b0;
    iter_en   = 1'b0;
    iter_last = 1'b0;
    fix_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    dz_err    = 1'b0;
    case (state)
      INIT: begin
        load_op = 1'b1;
        busy    = 1'b1;
      end
      ITER: begin
        iter_en   = 1'b1;
        iter_last = (iter_cnt == LAST_CNT);
        busy      = 1'b1;
      end
      FIX: begin
        fix_en = rem_neg;
        busy   = 1'b1;
      end
      DONE: begin
        done   = 1'b1;
        busy   = 1'b1;
        dz_err = dz_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_srt4_div_ctrl.sv
// tb/tb_srt4_div_ctrl.sv - scoreboard bench for srt4_div_ctrl
// Three instances cover the default, single-iteration and 32-iteration configurations.
module tb_srt4_div_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic abort = 1'b0;
  logic divisor_zero = 1'b0;
  logic rem_neg = 1'b0;
  logic done_ack = 1'b0;
  logic [2:0] start = 3'b000;
  logic [2:0] load_op, iter_en, iter_last, fix_en, busy, done, dz_err;
  logic [4:0] cnt0;
  logic [0:0] cnt1;
  logic [4:0] cnt2;

  always #5 clk = ~clk;

  srt4_div_ctrl #(.ITERATIONS(24), .CNT_W(5)) u_def (
    .clk(clk), .resetn(resetn), .start(start[0]), .abort(abort),
    .divisor_zero(divisor_zero), .rem_neg(rem_neg), .done_ack(done_ack),
    .load_op(load_op[0]), .iter_en(iter_en[0]), .iter_last(iter_last[0]),
    .fix_en(fix_en[0]), .busy(busy[0]), .done(done[0]), .dz_err(dz_err[0]),
    .iter_cnt(cnt0));

  srt4_div_ctrl #(.ITERATIONS(1), .CNT_W(1)) u_one (
    .clk(clk), .resetn(resetn), .start(start[1]), .abort(abort),
    .divisor_zero(divisor_zero), .rem_neg(rem_neg), .done_ack(done_ack),
    .load_op(load_op[1]), .iter_en(iter_en[1]), .iter_last(iter_last[1]),
    .fix_en(fix_en[1]), .busy(busy[1]), .done(done[1]), .dz_err(dz_err[1]),
    .iter_cnt(cnt1));

  srt4_div_ctrl #(.ITERATIONS(32), .CNT_W(5)) u_big (
    .clk(clk), .resetn(resetn), .start(start[2]), .abort(abort),
    .divisor_zero(divisor_zero), .rem_neg(rem_neg), .done_ack(done_ack),
    .load_op(load_op[2]), .iter_en(iter_en[2]), .iter_last(iter_last[2]),
    .fix_en(fix_en[2]), .busy(busy[2]), .done(done[2]), .dz_err(dz_err[2]),
    .iter_cnt(cnt2));

  int sel = 0;
  logic o_load, o_iter, o_last, o_fix, o_busy, o_done, o_dz;
  int o_cnt;

  always_comb begin
    o_load = load_op[sel];
    o_iter = iter_en[sel];
    o_last = iter_last[sel];
    o_fix  = fix_en[sel];
    o_busy = busy[sel];
    o_done = done[sel];
    o_dz   = dz_err[sel];
    o_cnt  = (sel == 0) ? int'(cnt0) : (sel == 1) ? int'(cnt1) : int'(cnt2);
  end

  typedef struct {
    int   lat;
    int   loads;
    int   iters;
    int   lasts;
    int   last_cnt;
    int   fixes;
    int   fix_n;
    int   max_cnt;
    logic dz;
  } res_t;

  res_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  // One division on instance s; expectation is pushed before stimulus and popped at completion
  task automatic run_div(input int s, input logic dz, input logic rn, input int hold,
                         input logic ack_start);
    res_t e;
    res_t o;
    int   n_it;
    n_it       = (s == 0) ? 24 : (s == 1) ? 1 : 32;
    e.lat      = dz ? 0 : n_it + 2;
    e.loads    = dz ? 0 : 1;
    e.iters    = dz ? 0 : n_it;
    e.lasts    = dz ? 0 : 1;
    e.last_cnt = dz ? -1 : n_it - 1;
    e.fixes    = (!dz && rn) ? 1 : 0;
    e.fix_n    = (!dz && rn) ? n_it + 1 : -1;
    e.max_cnt  = dz ? 0 : n_it - 1;
    e.dz       = dz;
    exp_q.push_back(e);

    o.lat = -1; o.loads = 0; o.iters = 0; o.lasts = 0; o.last_cnt = -1;
    o.fixes = 0; o.fix_n = -1; o.max_cnt = 0; o.dz = 1'b0;

    sel = s;
    @(negedge clk);
    divisor_zero = dz;
    rem_neg = rn;
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    divisor_zero = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (o_load) o.loads++;
      if (o_iter) o.iters++;
      if (o_last) begin o.lasts++; o.last_cnt = o_cnt; end
      if (o_fix) begin o.fixes++; o.fix_n = n; end
      if (o_cnt > o.max_cnt) o.max_cnt = o_cnt;
      if (o_done) begin o.lat = n; o.dz = o_dz; break; end
      @(negedge clk);
    end

    e = exp_q.pop_front();
    compared++;
    if (o.lat !== e.lat) begin
      mismatched++;
      $display("FAIL latency inst=%0d got %0d expected %0d (-1 = timeout)", s, o.lat, e.lat);
    end
    if (o.lat >= 0) begin
      compared++;
      if (o.loads !== e.loads) begin mismatched++; $display("FAIL load_op_cycles inst=%0d got %0d expected %0d", s, o.loads, e.loads); end
      compared++;
      if (o.iters !== e.iters) begin mismatched++; $display("FAIL iter_en_cycles inst=%0d got %0d expected %0d", s, o.iters, e.iters); end
      compared++;
      if (o.lasts !== e.lasts) begin mismatched++; $display("FAIL iter_last_cycles inst=%0d got %0d expected %0d", s, o.lasts, e.lasts); end
      compared++;
      if (o.last_cnt !== e.last_cnt) begin mismatched++; $display("FAIL iter_last_cnt inst=%0d got %0d expected %0d", s, o.last_cnt, e.last_cnt); end
      compared++;
      if (o.fixes !== e.fixes) begin mismatched++; $display("FAIL fix_en_cycles inst=%0d got %0d expected %0d", s, o.fixes, e.fixes); end
      compared++;
      if (o.fix_n !== e.fix_n) begin mismatched++; $display("FAIL fix_en_time inst=%0d got %0d expected %0d", s, o.fix_n, e.fix_n); end
      compared++;
      if (o.max_cnt !== e.max_cnt) begin mismatched++; $display("FAIL max_iter_cnt inst=%0d got %0d expected %0d", s, o.max_cnt, e.max_cnt); end
      compared++;
      if (o.dz !== e.dz) begin mismatched++; $display("FAIL dz_err inst=%0d got %0b expected %0b", s, o.dz, e.dz); end

      for (int h = 0; h < hold; h++) begin
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
        compared++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_dz !== e.dz || o_load !== 1'b0) begin
          mismatched++;
          $display("FAIL done_hold inst=%0d cycle=%0d got done=%0b busy=%0b dz=%0b load=%0b expected 1 1 %0b 0",
                   s, h, o_done, o_busy, o_dz, o_load, e.dz);
        end
      end
    end

    done_ack = 1'b1;
    start[s] = ack_start;
    @(negedge clk);
    done_ack = 1'b0;
    start[s] = 1'b0;
    compared++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      mismatched++;
      $display("FAIL after_ack inst=%0d got busy=%0b done=%0b expected 0 0", s, o_busy, o_done);
    end
    if (ack_start) begin
      @(negedge clk);
      compared++;
      if (o_busy !== 1'b0 || o_load !== 1'b0) begin
        mismatched++;
        $display("FAIL ack_start_ignored got busy=%0b load_op=%0b expected 0 0", o_busy, o_load);
      end
    end
    rem_neg = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    compared++;
    if (busy !== 3'b000 || done !== 3'b000 || load_op !== 3'b000 || iter_en !== 3'b000 ||
        dz_err !== 3'b000 || cnt0 !== 5'd0) begin
      mismatched++;
      $display("FAIL reset_state got busy=%b done=%b load=%b iter=%b dz=%b cnt=%0d expected all 0",
               busy, done, load_op, iter_en, dz_err, cnt0);
    end
    @(negedge clk);
    resetn = 1'b1;
    sel = 0;
    start[0] = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort = 1'b0;
    compared++;
    if (o_busy !== 1'b0 || o_load !== 1'b0) begin
      mismatched++;
      $display("FAIL start_abort_idle got busy=%0b load_op=%0b expected 0 0", o_busy, o_load);
    end
  endtask

  task automatic wait_cnt(input int target, input logic want_last);
    int k;
    k = 0;
    while (!(o_iter && o_cnt == target && (!want_last || o_last)) && k < 100) begin
      @(negedge clk);
      k++;
    end
    compared++;
    if (k >= 100) begin
      mismatched++;
      $display("FAIL wait_iter_cnt got timeout expected iter_cnt=%0d", target);
    end
  endtask

  task automatic test_abort();
    int done_seen;
    sel = 0;
    rem_neg = 1'b1;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_cnt(10, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    compared++;
    if (o_busy !== 1'b0 || o_cnt !== 0 || o_done !== 1'b0 || o_iter !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_mid got busy=%0b cnt=%0d done=%0b iter_en=%0b expected 0 0 0 0",
               o_busy, o_cnt, o_done, o_iter);
    end
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_done || o_busy) done_seen++;
      @(negedge clk);
    end
    compared++;
    if (done_seen !== 0) begin
      mismatched++;
      $display("FAIL abort_quiet got %0d active cycles expected 0", done_seen);
    end

    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_cnt(23, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_fix || o_done || o_busy) done_seen++;
      @(negedge clk);
    end
    compared++;
    if (done_seen !== 0) begin
      mismatched++;
      $display("FAIL abort_last got %0d cycles with fix_en/done/busy expected 0", done_seen);
    end
    rem_neg = 1'b0;
  endtask

  task automatic test_async_reset();
    sel = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_cnt(5, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    compared++;
    if (o_busy !== 1'b0 || o_iter !== 1'b0 || o_cnt !== 0 || o_done !== 1'b0 || o_load !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset got busy=%0b iter_en=%0b cnt=%0d done=%0b load=%0b expected all 0",
               o_busy, o_iter, o_cnt, o_done, o_load);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    compared++;
    if (o_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset_idle got busy=%0b expected 0", o_busy);
    end
  endtask

  initial begin
    test_reset();
    run_div(0, 1'b0, 1'b0, 0, 1'b0);  // nominal
    run_div(0, 1'b0, 1'b1, 0, 1'b0);  // correction
    run_div(0, 1'b1, 1'b0, 0, 1'b0);  // divide by zero
    run_div(0, 1'b0, 1'b0, 0, 1'b0);  // clears dz_err
    run_div(0, 1'b1, 1'b0, 5, 1'b1);  // hold, start ignored, ack with start
    run_div(0, 1'b0, 1'b1, 5, 1'b0);
    test_abort();
    test_async_reset();
    run_div(1, 1'b0, 1'b1, 0, 1'b0);
    run_div(1, 1'b0, 1'b0, 0, 1'b0);
    run_div(2, 1'b0, 1'b1, 0, 1'b0);
    run_div(2, 1'b1, 1'b0, 1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
